// File: rtl/ym_psg_pkg.sv
// Shared types and constants for the ZX-bus PSG front end.
package ym_psg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Bus-cycle mode, packed as {bdir, bc1}
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_INACT = 2'b00;
    localparam mode_t MODE_READ  = 2'b01;
    localparam mode_t MODE_WRITE = 2'b10;
    localparam mode_t MODE_LATCH = 2'b11;

    localparam logic [15:0] PORT_REG   = 16'hFFFD;
    localparam logic [15:0] PORT_DAT   = 16'hBFFD;
    localparam logic [7:0]  PORT_FE    = 8'hFE;
    localparam logic [7:0]  PORT_COVOX = 8'hFB;
    localparam logic [7:0]  SEL_BASE   = 8'hFF;

    // Mode for a decoded PSG access; a read of the data port is a no-op
    function automatic mode_t access_mode(input logic reg_sel, input logic is_wr);
        if (reg_sel)
            return is_wr ? MODE_LATCH : MODE_READ;
        return is_wr ? MODE_WRITE : MODE_INACT;
    endfunction

endpackage

// File: rtl/ym_psg_bus_ctrl_clk_gen.sv
// PSG clock generator: cpu_clock divided by YM_DIV, with a bypass mux
// whose select is only re-sampled when the divided clock rises, so the
// mux never switches against a clock that is heading the other way.
module ym_clk_gen
    import ym_psg_pkg::*;
#(
    parameter int YM_DIV = 2
) (
    input  logic cpu_clock,
    input  logic reset,
    input  logic ym_bypass,
    output logic ym_clk
);

    localparam logic [3:0] LAST = 4'(YM_DIV / 2 - 1);

    logic [3:0] r_cnt;
    logic       r_clk;
    logic       r_byp;
    logic       w_wrap;

    assign w_wrap = (r_cnt == LAST);

    // Half-period counter; toggle on wrap, pick up bypass on the rising toggle
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_clk <= 1'b0;
            r_byp <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= 4'd0;
            r_clk <= ~r_clk;
            if (!r_clk)
                r_byp <= ym_bypass;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign ym_clk = r_byp ? cpu_clock : r_clk;

endmodule

// File: rtl/ym_psg_bus_ctrl.sv
// ZX-bus front end for N_CHIPS AY/YM PSGs: #FFFD/#BFFD decode, registered
// BDIR/BC1 bus-cycle FSM, chip-select register, PSG clock, IORQGE and #FE.
// Optional feature macro: COVOX_EN (adds an 8-bit DAC latch on port #FB).
module ym_psg_bus_ctrl
    import ym_psg_pkg::*;
#(
    parameter int N_CHIPS  = 2,
    parameter int YM_DIV   = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic               cpu_clock,
    input  logic               reset,
    input  logic [15:0]        a,
    input  logic [7:0]         d,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic               ym_bypass,
    output logic               bdir,
    output logic               bc1,
    output logic [N_CHIPS-1:0] ym_sel_n,
    output logic               ym_clk,
    output logic               iorqge,
    output logic               beeper,
`ifdef COVOX_EN
    output logic [7:0]         covox_data,
    output logic               covox_stb,
`endif
    output logic               tapeout
);

    logic       w_psg, w_reg_sel, w_data, w_wr, w_rd;
    logic       w_io_acc, w_start, w_sel_hit, w_io_fe;
    logic [7:0] w_k;
    mode_t      w_mode_new;
    logic       w_unused;

    state_t     r_state, w_state_nxt;
    mode_t      r_mode, w_mode_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [N_CHIPS-1:0] r_sel_n;
    logic       r_iorqge, r_fe_q, r_beeper, r_tapeout;

    // Legacy partial decode: only a15, a14, a13 and a3..a0 take part
    assign w_psg      = (a[15] == PORT_REG[15]) && (a[3:0] == PORT_REG[3:0]);
    assign w_reg_sel  = w_psg && (a[14:13] == PORT_REG[14:13]);
    assign w_data     = w_psg && (a[14] == PORT_DAT[14]);
    assign w_wr       = ~wr_n;
    assign w_rd       = ~rd_n;
    assign w_io_acc   = ~iorq_n & m1_n & w_psg & (w_wr | w_rd);
    assign w_unused   = &{1'b0, a[12:4]};

    // Select write: data 0xFF-k on #FFFD picks chip k and is not forwarded
    assign w_k        = SEL_BASE - d;
    assign w_sel_hit  = w_reg_sel & w_wr & (w_k < 8'(N_CHIPS));
    assign w_mode_new = w_sel_hit ? MODE_INACT : access_mode(w_reg_sel, w_wr);
    // #BFFD read and the a14=1/a13=0 hole start no bus cycle
    assign w_start    = w_io_acc & (w_reg_sel | (w_data & w_wr));

    // FSM state, mode and chip-select registers
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_INACT;
            r_cnt   <= 2'd0;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Next-state: mode is only ever replaced whole, never blended
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_start) begin
                    w_state_nxt = ST_ACCESS;
                    w_mode_nxt  = w_mode_new;
                    if (w_sel_hit)
                        w_sel_nxt = w_k[1:0];
                end else if (r_state == ST_HOLD) begin
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_mode_nxt  = MODE_INACT;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!w_io_acc) begin
                    if (HOLD_CYC == 0) begin
                        w_state_nxt = ST_IDLE;
                        w_mode_nxt  = MODE_INACT;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = 2'(HOLD_CYC);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mode_nxt  = MODE_INACT;
            end
        endcase
    end

    // Bus controls come straight from the registered mode
    always_comb begin
        {bdir, bc1} = r_mode;
    end

    // One-hot-low select, one cycle behind the select register
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset)
            r_sel_n <= ~N_CHIPS'(1);
        else
            r_sel_n <= ~(N_CHIPS'(1) << r_sel);
    end

    assign ym_sel_n = r_sel_n;

    // IORQGE claims our ports independent of IORQ timing
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset)
            r_iorqge <= 1'b0;
        else
            r_iorqge <= m1_n & w_psg & (a[14] ? a[13] : 1'b1);
    end

    assign iorqge = r_iorqge;

    assign w_io_fe = ~iorq_n & ~wr_n & (a[0] == PORT_FE[0]);

    // #FE latch on the first cycle of a write only
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_fe_q    <= 1'b0;
            r_beeper  <= 1'b0;
            r_tapeout <= 1'b0;
        end else begin
            r_fe_q <= w_io_fe;
            if (w_io_fe && !r_fe_q) begin
                r_beeper  <= d[4];
                r_tapeout <= d[3];
            end
        end
    end

    assign beeper  = r_beeper;
    assign tapeout = r_tapeout;

`ifdef COVOX_EN
    logic       w_io_cv;
    logic       r_cv_q, r_cv_stb;
    logic [7:0] r_cv_data;

    assign w_io_cv = ~iorq_n & ~wr_n & (a[7:0] == PORT_COVOX);

    // Covox DAC latch with a single-cycle strobe per write
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_cv_q    <= 1'b0;
            r_cv_stb  <= 1'b0;
            r_cv_data <= 8'h80;
        end else begin
            r_cv_q   <= w_io_cv;
            r_cv_stb <= w_io_cv & ~r_cv_q;
            if (w_io_cv && !r_cv_q)
                r_cv_data <= d;
        end
    end

    assign covox_data = r_cv_data;
    assign covox_stb  = r_cv_stb;
`endif

    ym_clk_gen #(.YM_DIV(YM_DIV)) u_clk_gen (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .ym_bypass (ym_bypass),
        .ym_clk    (ym_clk)
    );

endmodule

// File: tb/tb_ym_psg_bus_ctrl.sv
// Directed bench for ym_psg_bus_ctrl (4 chips, /4 PSG clock, 1 hold cycle).
module tb_ym_psg_bus_ctrl;
    import ym_psg_pkg::*;

    localparam int NC = 4;

    logic          cpu_clock = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   a;
    logic [7:0]    d;
    logic          m1_n, iorq_n, wr_n, rd_n, ym_bypass;
    logic          bdir, bc1, ym_clk, iorqge, beeper, tapeout;
    logic [NC-1:0] ym_sel_n;
`ifdef COVOX_EN
    logic [7:0]    covox_data;
    logic          covox_stb;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] obs [8];
    int         glitches = 0;
    bit         mon_en = 1'b0;
    time        t_last = 0;

    always #5 cpu_clock = ~cpu_clock;

    ym_psg_bus_ctrl #(.N_CHIPS(NC), .YM_DIV(4), .HOLD_CYC(1)) dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .a         (a),
        .d         (d),
        .m1_n      (m1_n),
        .iorq_n    (iorq_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .ym_bypass (ym_bypass),
        .bdir      (bdir),
        .bc1       (bc1),
        .ym_sel_n  (ym_sel_n),
        .ym_clk    (ym_clk),
        .iorqge    (iorqge),
        .beeper    (beeper),
`ifdef COVOX_EN
        .covox_data(covox_data),
        .covox_stb (covox_stb),
`endif
        .tapeout   (tapeout)
    );

    // Shortest ym_clk level seen while the monitor is armed
    always @(ym_clk) begin
        if (mon_en && ($time - t_last) < 5)
            glitches++;
        t_last = $time;
    end

    // One I/O cycle of len clocks; records {bdir,bc1} after each of len+3 edges
    task automatic do_io(input logic [15:0] addr, input logic [7:0] data,
                         input logic wr, input int len);
        @(negedge cpu_clock);
        a = addr; d = data; iorq_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(posedge cpu_clock); #1;
            obs[i] = {bdir, bc1};
        end
        @(negedge cpu_clock);
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        for (int i = len; i < len + 3; i++) begin
            @(posedge cpu_clock); #1;
            obs[i] = {bdir, bc1};
        end
    endtask

    task automatic test_reset();
        a = 16'h0000; d = 8'h00; m1_n = 1'b1; iorq_n = 1'b1;
        wr_n = 1'b1; rd_n = 1'b1; ym_bypass = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge cpu_clock);
        #1;
        n_cmp++;
        if ({bdir, bc1} !== 2'b00) begin
            n_err++; $display("FAIL reset_bus: got %b want 00", {bdir, bc1});
        end
        n_cmp++;
        if (ym_sel_n !== 4'b1110) begin
            n_err++; $display("FAIL reset_sel: got %b want 1110", ym_sel_n);
        end
        n_cmp++;
        if ({ym_clk, iorqge, beeper, tapeout} !== 4'b0000) begin
            n_err++; $display("FAIL reset_misc: got %b want 0000", {ym_clk, iorqge, beeper, tapeout});
        end
        @(negedge cpu_clock);
        reset = 1'b1;
    endtask

    task automatic test_write_seq();
        logic [1:0] exp;
        do_io(PORT_REG, 8'h07, 1'b1, 2);
        for (int i = 0; i < 5; i++) begin
            exp = (i < 3) ? MODE_LATCH : MODE_INACT;
            n_cmp++;
            if (obs[i] !== exp) begin
                n_err++; $display("FAIL latch_seq[%0d]: got %b want %b", i, obs[i], exp);
            end
        end
        do_io(PORT_DAT, 8'h3E, 1'b1, 2);
        for (int i = 0; i < 5; i++) begin
            exp = (i < 3) ? MODE_WRITE : MODE_INACT;
            n_cmp++;
            if (obs[i] !== exp) begin
                n_err++; $display("FAIL write_seq[%0d]: got %b want %b", i, obs[i], exp);
            end
        end
        n_cmp++;
        if (ym_sel_n !== 4'b1110) begin
            n_err++; $display("FAIL write_sel_kept: got %b want 1110", ym_sel_n);
        end
    endtask

    task automatic test_select();
        logic [7:0] dv [4];
        logic [1:0] em [4];
        logic [3:0] es [4];
        dv = '{8'hFD, 8'hFB, 8'hFC, 8'hFF};
        em = '{2'b00, 2'b11, 2'b00, 2'b00};
        es = '{4'b1011, 4'b1011, 4'b0111, 4'b1110};
        for (int j = 0; j < 4; j++) begin
            do_io(PORT_REG, dv[j], 1'b1, 2);
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs[i] !== ((i < 3) ? em[j] : 2'b00)) begin
                    n_err++; $display("FAIL select_bus d=%h [%0d]: got %b want %b", dv[j], i, obs[i], (i < 3) ? em[j] : 2'b00);
                end
            end
            n_cmp++;
            if (ym_sel_n !== es[j]) begin
                n_err++; $display("FAIL select_sel d=%h: got %b want %b", dv[j], ym_sel_n, es[j]);
            end
        end
    endtask

    task automatic test_read_iorqge();
        do_io(PORT_REG, 8'h00, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs[i] !== ((i < 3) ? MODE_READ : MODE_INACT)) begin
                n_err++; $display("FAIL read_seq[%0d]: got %b want %b", i, obs[i], (i < 3) ? MODE_READ : MODE_INACT);
            end
        end
        do_io(PORT_DAT, 8'h00, 1'b0, 2);
        n_cmp++;
        if ({obs[0], obs[1], obs[2]} !== 6'b000000) begin
            n_err++; $display("FAIL dat_read_noop: got %b want 000000", {obs[0], obs[1], obs[2]});
        end
        m1_n = 1'b0;
        do_io(PORT_REG, 8'h07, 1'b1, 2);
        m1_n = 1'b1;
        n_cmp++;
        if ({obs[0], obs[1], obs[2]} !== 6'b000000) begin
            n_err++; $display("FAIL m1_blocks: got %b want 000000", {obs[0], obs[1], obs[2]});
        end
        @(negedge cpu_clock); a = 16'h0000;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if (iorqge !== 1'b0) begin
            n_err++; $display("FAIL iorqge_idle: got %b want 0", iorqge);
        end
        @(negedge cpu_clock); a = PORT_REG; #1;
        n_cmp++;
        if (iorqge !== 1'b0) begin
            n_err++; $display("FAIL iorqge_latency: got %b want 0", iorqge);
        end
        @(posedge cpu_clock); #1;
        n_cmp++;
        if (iorqge !== 1'b1) begin
            n_err++; $display("FAIL iorqge_reg: got %b want 1", iorqge);
        end
        @(negedge cpu_clock); a = 16'hDFFD;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if (iorqge !== 1'b0) begin
            n_err++; $display("FAIL iorqge_dffd: got %b want 0", iorqge);
        end
        @(negedge cpu_clock); a = PORT_DAT;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if (iorqge !== 1'b1) begin
            n_err++; $display("FAIL iorqge_dat: got %b want 1", iorqge);
        end
        @(negedge cpu_clock); m1_n = 1'b0;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if (iorqge !== 1'b0) begin
            n_err++; $display("FAIL iorqge_m1: got %b want 0", iorqge);
        end
        @(negedge cpu_clock); m1_n = 1'b1; a = 16'h0000;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp [5];
        exp = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
        @(negedge cpu_clock);
        a = PORT_REG; d = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge cpu_clock); #1; obs[0] = {bdir, bc1};
        @(negedge cpu_clock); iorq_n = 1'b1; wr_n = 1'b1;
        @(posedge cpu_clock); #1; obs[1] = {bdir, bc1};
        @(negedge cpu_clock);
        a = PORT_DAT; d = 8'h3E; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge cpu_clock); #1; obs[2] = {bdir, bc1};
        @(negedge cpu_clock); iorq_n = 1'b1; wr_n = 1'b1;
        @(posedge cpu_clock); #1; obs[3] = {bdir, bc1};
        @(posedge cpu_clock); #1; obs[4] = {bdir, bc1};
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs[i] !== exp[i]) begin
                n_err++; $display("FAIL b2b[%0d]: got %b want %b", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        do_io(PORT_REG, 8'hFD, 1'b1, 1);
        n_cmp++;
        if (ym_sel_n !== 4'b1011) begin
            n_err++; $display("FAIL rst_presel: got %b want 1011", ym_sel_n);
        end
        @(negedge cpu_clock);
        a = PORT_REG; d = 8'h07; iorq_n = 1'b0; wr_n = 1'b0;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if ({bdir, bc1} !== 2'b11) begin
            n_err++; $display("FAIL rst_access: got %b want 11", {bdir, bc1});
        end
        reset = 1'b0; #1;
        n_cmp++;
        if ({bdir, bc1} !== 2'b00) begin
            n_err++; $display("FAIL rst_async: got %b want 00", {bdir, bc1});
        end
        @(negedge cpu_clock);
        iorq_n = 1'b1; wr_n = 1'b1; reset = 1'b1;
        @(posedge cpu_clock); #1;
        n_cmp++;
        if ({bdir, bc1, ym_sel_n} !== 6'b00_1110) begin
            n_err++; $display("FAIL rst_release: got %b want 001110", {bdir, bc1, ym_sel_n});
        end
    endtask

    task automatic test_clock();
        logic       prev;
        bit         found;
        int         n, hi;
        logic [9:0] exp_pos, exp_neg;
        exp_pos = 10'b0111111001;
        exp_neg = 10'b0110000001;
        mon_en = 1'b1;
        found = 1'b0;
        @(posedge cpu_clock); #1; prev = ym_clk;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge cpu_clock); #1;
            if (!prev && ym_clk) found = 1'b1;
            prev = ym_clk;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL clk_sync: got no rising ym_clk within 16 cycles, want one");
        end
        n = 0; hi = 0; found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge cpu_clock); #1;
            n++;
            if (ym_clk) hi++;
            if (!prev && ym_clk) found = 1'b1;
            prev = ym_clk;
        end
        n_cmp++;
        if (n !== 4 || hi !== 2) begin
            n_err++; $display("FAIL clk_period: got period %0d high %0d want 4 / 2", n, hi);
        end
        @(negedge cpu_clock); ym_bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge cpu_clock); #1;
            n_cmp++;
            if (ym_clk !== exp_pos[i]) begin
                n_err++; $display("FAIL clk_byp_pos[%0d]: got %b want %b", i, ym_clk, exp_pos[i]);
            end
            @(negedge cpu_clock); #1;
            n_cmp++;
            if (ym_clk !== exp_neg[i]) begin
                n_err++; $display("FAIL clk_byp_neg[%0d]: got %b want %b", i, ym_clk, exp_neg[i]);
            end
            if (i == 4) ym_bypass = 1'b0;
        end
        mon_en = 1'b0;
        n_cmp++;
        if (glitches !== 0) begin
            n_err++; $display("FAIL clk_glitch: got %0d short pulses want 0", glitches);
        end
    endtask

    task automatic test_fe();
        logic [7:0] dv [3];
        logic [1:0] ev [3];
        dv = '{8'h18, 8'h08, 8'h10};
        ev = '{2'b11, 2'b01, 2'b10};
        for (int j = 0; j < 3; j++) begin
            @(negedge cpu_clock);
            a = {8'h00, PORT_FE}; d = dv[j]; iorq_n = 1'b0; wr_n = 1'b0;
            @(posedge cpu_clock); #1;
            n_cmp++;
            if ({beeper, tapeout} !== ev[j]) begin
                n_err++; $display("FAIL fe_latch d=%h: got %b want %b", dv[j], {beeper, tapeout}, ev[j]);
            end
            @(negedge cpu_clock); d = ~dv[j];
            @(posedge cpu_clock); #1;
            n_cmp++;
            if ({beeper, tapeout} !== ev[j]) begin
                n_err++; $display("FAIL fe_edge_only d=%h: got %b want %b", dv[j], {beeper, tapeout}, ev[j]);
            end
            @(negedge cpu_clock); iorq_n = 1'b1; wr_n = 1'b1;
            @(posedge cpu_clock);
        end
    endtask

`ifdef COVOX_EN
    task automatic test_covox();
        int stb_cnt;
        #1;
        n_cmp++;
        if ({covox_data, covox_stb} !== {8'h80, 1'b0}) begin
            n_err++; $display("FAIL covox_reset: got %h/%b want 80/0", covox_data, covox_stb);
        end
        stb_cnt = 0;
        @(negedge cpu_clock);
        a = {8'h00, PORT_COVOX}; d = 8'h42; iorq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge cpu_clock); #1;
            if (covox_stb) stb_cnt++;
        end
        @(negedge cpu_clock); iorq_n = 1'b1; wr_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge cpu_clock); #1;
            if (covox_stb) stb_cnt++;
        end
        n_cmp++;
        if (covox_data !== 8'h42 || stb_cnt !== 1) begin
            n_err++; $display("FAIL covox_write: got %h / %0d strobes want 42 / 1", covox_data, stb_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_seq();
        test_select();
        test_read_iorqge();
        test_back_to_back();
        test_reset_mid_access();
        test_clock();
        test_fe();
`ifdef COVOX_EN
        test_covox();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
